// File: rtl/crc_pkg.sv
// Shared types and bit-serial CRC helpers for the streaming CRC engine.
// crc_t is a container sized for the widest supported CRC_DEGREE (64); callers pass the live width.
package crc_pkg;

  localparam int unsigned CRC_MAX_W = 64;

  typedef logic [CRC_MAX_W-1:0] crc_t;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  function automatic crc_t crc_mask(input int unsigned width);
    crc_t m;
    m = '1;
    return m >> (CRC_MAX_W - width);
  endfunction

  function automatic crc_t bit_reverse(input crc_t value, input int unsigned width);
    crc_t r;
    r = '0;
    for (int unsigned i = 0; i < CRC_MAX_W; i++) begin
      if (i < width) r[i] = value[width-1-i];
    end
    return r;
  endfunction

  // Normal-form LFSR on the unreflected register; reflection only changes the bit feed order.
  function automatic crc_t crc_byte_step(input crc_t crc, input logic [7:0] data_byte,
                                         input crc_t poly, input logic reflect,
                                         input int unsigned width);
    crc_t c;
    logic fb;
    c = crc;
    for (int unsigned i = 0; i < 8; i++) begin
      fb = c[width-1] ^ (reflect ? data_byte[i] : data_byte[7-i]);
      c  = c << 1;
      if (fb) c = c ^ poly;
    end
    return c & crc_mask(width);
  endfunction

endpackage

// File: rtl/crc_word_update.sv
// Combinational per-beat CRC update: chains one byte step per enabled lane, lane 0 first,
// stopping at the first disabled lane.
module crc_word_update
  import crc_pkg::*;
#(
  parameter int unsigned             CRC_DEGREE = 32,
  parameter int unsigned             BYTES_NUM  = 4,
  parameter logic [CRC_DEGREE-1:0]   POLY       = 32'h04C11DB7,
  parameter bit                      REFLECT_IN = 1'b1
) (
  input  logic [CRC_DEGREE-1:0]      crc_in,
  input  logic [BYTES_NUM-1:0][7:0]  data,
  input  logic [BYTES_NUM-1:0]       byte_vld,
  output logic [CRC_DEGREE-1:0]      crc_next
);

  localparam crc_t POLY_W = crc_t'(POLY);

  crc_t c_w;
  logic active_w;

  always_comb begin
    c_w      = crc_t'(crc_in);
    active_w = 1'b1;
    for (int unsigned i = 0; i < BYTES_NUM; i++) begin
      active_w = active_w & byte_vld[i];
      if (active_w) c_w = crc_byte_step(c_w, data[i], POLY_W, REFLECT_IN, CRC_DEGREE);
    end
    crc_next = CRC_DEGREE'(c_w);
  end

endmodule

// File: rtl/crc_stream_engine.sv
// Streaming CRC generator/checker with valid/ready on input beats and result.
// Optional FCS residue comparison (crc_ok port) is enabled by defining CRC_CHECK_EN.
module crc_stream_engine
  import crc_pkg::*;
#(
  parameter int unsigned             CRC_DEGREE  = 32,
  parameter int unsigned             BYTES_NUM   = 4,
  parameter logic [CRC_DEGREE-1:0]   POLY        = 32'h04C11DB7,
  parameter logic [CRC_DEGREE-1:0]   INIT        = 32'hFFFFFFFF,
  parameter logic [CRC_DEGREE-1:0]   XOR_OUT     = 32'hFFFFFFFF,
  parameter bit                      REFLECT_IN  = 1'b1,
  parameter bit                      REFLECT_OUT = 1'b1
`ifdef CRC_CHECK_EN
  ,
  parameter logic [CRC_DEGREE-1:0]   RESIDUE     = 32'h2144DF1C
`endif
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [BYTES_NUM-1:0][7:0]  s_data,
  input  logic [BYTES_NUM-1:0]       s_byte_vld,
  input  logic                       s_vld,
  input  logic                       s_last,
  output logic                       s_rdy,
  output logic [CRC_DEGREE-1:0]      crc_out,
  output logic                       crc_err,
  output logic                       crc_vld,
  input  logic                       crc_rdy
`ifdef CRC_CHECK_EN
  ,
  output logic                       crc_ok
`endif
);

  state_t                 state_q, state_d;
  logic [CRC_DEGREE-1:0]  crc_q, crc_d;
  logic                   err_q, err_d;
  logic [CRC_DEGREE-1:0]  crc_out_q, crc_out_d;
  logic                   crc_err_q, crc_err_d;
  logic [CRC_DEGREE-1:0]  crc_next;
  logic [CRC_DEGREE-1:0]  final_crc;
  logic [BYTES_NUM-1:0]   vld_plus1;
  logic                   accept;
  logic                   beat_err;

  crc_word_update #(
    .CRC_DEGREE (CRC_DEGREE),
    .BYTES_NUM  (BYTES_NUM),
    .POLY       (POLY),
    .REFLECT_IN (REFLECT_IN)
  ) u_word_update (
    .crc_in   (crc_q),
    .data     (s_data),
    .byte_vld (s_byte_vld),
    .crc_next (crc_next)
  );

  // Taking the result frees the engine in the same cycle, so a new beat can enter while in HOLD.
  assign s_rdy  = (state_q == ACCUM) || crc_rdy;
  assign accept = s_vld && s_rdy;

  always_comb begin
    vld_plus1 = s_byte_vld + BYTES_NUM'(1);
    // Last beat needs a non-empty run of ones from lane 0: x & (x+1) == 0 detects 0..01..1.
    if (s_last) beat_err = !(s_byte_vld[0] && ((s_byte_vld & vld_plus1) == '0));
    else        beat_err = (s_byte_vld != '1);
    if (REFLECT_OUT) final_crc = CRC_DEGREE'(bit_reverse(crc_t'(crc_next), CRC_DEGREE)) ^ XOR_OUT;
    else             final_crc = crc_next ^ XOR_OUT;
  end

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    err_d     = err_q;
    crc_out_d = crc_out_q;
    crc_err_d = crc_err_q;
    if (state_q == HOLD && crc_rdy) state_d = ACCUM;
    if (accept) begin
      if (s_last) begin
        state_d   = HOLD;
        crc_d     = INIT;
        err_d     = 1'b0;
        crc_out_d = final_crc;
        crc_err_d = err_q | beat_err;
      end else begin
        crc_d = crc_next;
        err_d = err_q | beat_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ACCUM;
      crc_q     <= INIT;
      err_q     <= 1'b0;
      crc_out_q <= '0;
      crc_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      err_q     <= err_d;
      crc_out_q <= crc_out_d;
      crc_err_q <= crc_err_d;
    end
  end

  assign crc_out = crc_out_q;
  assign crc_err = crc_err_q;
  assign crc_vld = (state_q == HOLD);

`ifdef CRC_CHECK_EN
  logic crc_ok_q, crc_ok_d;

  always_comb begin
    crc_ok_d = crc_ok_q;
    if (accept && s_last) crc_ok_d = (final_crc == RESIDUE);
  end

  always_ff @(posedge clk) begin
    if (reset) crc_ok_q <= 1'b0;
    else       crc_ok_q <= crc_ok_d;
  end

  assign crc_ok = crc_ok_q;
`endif

endmodule

// File: tb/tb_crc_stream_engine.sv
// Directed self-checking bench for crc_stream_engine (CRC-32/Ethernet defaults).
// Residue tests run when CRC_CHECK_EN is defined.
module tb_crc_stream_engine;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0][7:0]  s_data;
  logic [3:0]       s_byte_vld;
  logic             s_vld;
  logic             s_last;
  logic             s_rdy;
  logic [31:0]      crc_out;
  logic             crc_err;
  logic             crc_vld;
  logic             crc_rdy;
`ifdef CRC_CHECK_EN
  logic             crc_ok;
`endif

  int checks = 0;
  int errors = 0;
  int beat_waits;
  int res_waits;

  localparam logic [31:0] CHECK_CRC = 32'hCBF43926;  // CRC-32("123456789")
  localparam logic [31:0] ABC_CRC   = 32'h352441C2;  // CRC-32("abc")

  always #5 clk = ~clk;

  crc_stream_engine #(
    .CRC_DEGREE (32),
    .BYTES_NUM  (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .s_data     (s_data),
    .s_byte_vld (s_byte_vld),
    .s_vld      (s_vld),
    .s_last     (s_last),
    .s_rdy      (s_rdy),
    .crc_out    (crc_out),
    .crc_err    (crc_err),
    .crc_vld    (crc_vld),
    .crc_rdy    (crc_rdy)
`ifdef CRC_CHECK_EN
    ,
    .crc_ok     (crc_ok)
`endif
  );

  // Presents a beat from the next falling edge and returns once it will be taken on the following rising edge.
  task automatic beat(input logic [31:0] d, input logic [3:0] en, input logic last);
    bit ok;
    ok = 1'b0;
    beat_waits = 0;
    @(negedge clk);
    s_data = d; s_byte_vld = en; s_last = last; s_vld = 1'b1;
    for (int n = 0; n < 50; n++) begin
      #1;
      if (s_rdy) begin ok = 1'b1; break; end
      beat_waits++;
      @(negedge clk);
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL beat_accept: s_rdy=0 for 50 cycles, required 1"); end
  endtask

  task automatic wait_result();
    bit got;
    got = 1'b0;
    res_waits = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      s_vld = 1'b0; s_last = 1'b0;
      if (crc_vld) begin got = 1'b1; break; end
      res_waits++;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL result_timeout: crc_vld=0 for 20 cycles, required 1"); end
  endtask

  task automatic send_123();
    beat(32'h34333231, 4'hF, 1'b0);
    beat(32'h38373635, 4'hF, 1'b0);
    beat(32'h00000039, 4'h1, 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1; s_vld = 1'b0; s_last = 1'b0; s_data = '0; s_byte_vld = '0; crc_rdy = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (crc_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b required 0", crc_vld); end
    checks++; if (crc_out !== 32'h0) begin errors++; $display("FAIL reset_out: got %h required 00000000", crc_out); end
    checks++; if (crc_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b required 0", crc_err); end
    checks++; if (s_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b required 1", s_rdy); end
  endtask

  task automatic test_basic_with_gap();
    crc_rdy = 1'b1;
    beat(32'h34333231, 4'hF, 1'b0);
    @(negedge clk);
    s_vld = 1'b0; s_data = 32'hDEADBEEF; s_byte_vld = 4'h0; s_last = 1'b1;
    beat(32'h38373635, 4'hF, 1'b0);
    beat(32'h00000039, 4'h1, 1'b1);
    wait_result();
    checks++; if (res_waits != 0) begin errors++; $display("FAIL basic_latency: got %0d extra cycles required 0", res_waits); end
    checks++; if (crc_out !== CHECK_CRC) begin errors++; $display("FAIL basic_crc: got %h required %h", crc_out, CHECK_CRC); end
    checks++; if (crc_err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b required 0", crc_err); end
    @(negedge clk);
    checks++; if (crc_vld !== 1'b0) begin errors++; $display("FAIL basic_taken: crc_vld got %b required 0", crc_vld); end
  endtask

  task automatic test_stall();
    crc_rdy = 1'b0;
    send_123();
    wait_result();
    s_data = 32'h00636261; s_byte_vld = 4'h7; s_last = 1'b1; s_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (crc_vld !== 1'b1) begin errors++; $display("FAIL stall_vld[%0d]: got %b required 1", i, crc_vld); end
      checks++; if (crc_out !== CHECK_CRC) begin errors++; $display("FAIL stall_out[%0d]: got %h required %h", i, crc_out, CHECK_CRC); end
      checks++; if (s_rdy !== 1'b0) begin errors++; $display("FAIL stall_rdy[%0d]: got %b required 0", i, s_rdy); end
      @(negedge clk);
    end
    crc_rdy = 1'b1;
    #1;
    checks++; if (s_rdy !== 1'b1) begin errors++; $display("FAIL stall_release_rdy: got %b required 1", s_rdy); end
    wait_result();
    checks++; if (crc_out !== ABC_CRC) begin errors++; $display("FAIL stall_next_crc: got %h required %h", crc_out, ABC_CRC); end
  endtask

  task automatic test_back_to_back();
    crc_rdy = 1'b1;
    send_123();
    beat(32'h00636261, 4'h7, 1'b1);
    checks++; if (beat_waits != 0) begin errors++; $display("FAIL b2b_accept: waited %0d cycles required 0", beat_waits); end
    checks++; if (crc_vld !== 1'b1) begin errors++; $display("FAIL b2b_vld1: got %b required 1", crc_vld); end
    checks++; if (crc_out !== CHECK_CRC) begin errors++; $display("FAIL b2b_crc1: got %h required %h", crc_out, CHECK_CRC); end
    wait_result();
    checks++; if (res_waits != 0) begin errors++; $display("FAIL b2b_latency2: got %0d extra cycles required 0", res_waits); end
    checks++; if (crc_out !== ABC_CRC) begin errors++; $display("FAIL b2b_crc2: got %h required %h", crc_out, ABC_CRC); end
    checks++; if (crc_err !== 1'b0) begin errors++; $display("FAIL b2b_err2: got %b required 0", crc_err); end
  endtask

  task automatic test_lane_err();
    crc_rdy = 1'b1;
    beat(32'h34333231, 4'b0111, 1'b0);
    beat(32'h38373635, 4'b0101, 1'b1);
    wait_result();
    checks++; if (crc_err !== 1'b1) begin errors++; $display("FAIL lane_err: got %b required 1", crc_err); end
    beat(32'h00636261, 4'h7, 1'b1);
    wait_result();
    checks++; if (crc_err !== 1'b0) begin errors++; $display("FAIL lane_err_cleared: got %b required 0", crc_err); end
    checks++; if (crc_out !== ABC_CRC) begin errors++; $display("FAIL lane_err_next_crc: got %h required %h", crc_out, ABC_CRC); end
  endtask

  task automatic test_midframe_reset();
    crc_rdy = 1'b1;
    beat(32'h34333231, 4'hF, 1'b0);
    beat(32'h38373635, 4'hF, 1'b0);
    @(negedge clk);
    s_vld = 1'b0; s_last = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (crc_vld !== 1'b0) begin errors++; $display("FAIL mrst_vld[%0d]: got %b required 0", i, crc_vld); end
      @(negedge clk);
    end
    checks++; if (crc_out !== 32'h0) begin errors++; $display("FAIL mrst_out: got %h required 00000000", crc_out); end
    send_123();
    wait_result();
    checks++; if (crc_out !== CHECK_CRC) begin errors++; $display("FAIL mrst_crc: got %h required %h", crc_out, CHECK_CRC); end
    checks++; if (crc_err !== 1'b0) begin errors++; $display("FAIL mrst_err: got %b required 0", crc_err); end
  endtask

`ifdef CRC_CHECK_EN
  task automatic test_residue();
    crc_rdy = 1'b1;
    beat(32'h34333231, 4'hF, 1'b0);
    beat(32'h38373635, 4'hF, 1'b0);
    beat(32'hF4392639, 4'hF, 1'b0);
    beat(32'h000000CB, 4'h1, 1'b1);
    wait_result();
    checks++; if (crc_ok !== 1'b1) begin errors++; $display("FAIL residue_ok: got %b required 1", crc_ok); end
    checks++; if (crc_out !== 32'h2144DF1C) begin errors++; $display("FAIL residue_out: got %h required 2144df1c", crc_out); end
    beat(32'h34333230, 4'hF, 1'b0);
    beat(32'h38373635, 4'hF, 1'b0);
    beat(32'hF4392639, 4'hF, 1'b0);
    beat(32'h000000CB, 4'h1, 1'b1);
    wait_result();
    checks++; if (crc_ok !== 1'b0) begin errors++; $display("FAIL residue_corrupt: got %b required 0", crc_ok); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_with_gap();
    test_stall();
    test_back_to_back();
    test_lane_err();
    test_midframe_reset();
`ifdef CRC_CHECK_EN
    test_residue();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
